// File: rtl/uart_rx_unescape.sv
// UART 8N1 receiver with byte-stuffing removal (flag/escape framing).
// Ports: mclk, reset (async low), rxd in; rx_data/strobe, rx_flag, rx_frame_err out.
module uart_rx_unescape #(
  parameter int          BIT_CLKS  = 50,
  parameter logic [7:0]  FLAG_BYTE = 8'h7E,
  parameter logic [7:0]  ESC_BYTE  = 8'h7D,
  parameter logic [7:0]  ESC_XOR   = 8'h20
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_strobe,
  output logic       rx_flag,
  output logic       rx_frame_err
);

  localparam logic [11:0] HALF = 12'(BIT_CLKS / 2 - 1);
  localparam logic [11:0] FULL = 12'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t      r_state;
  logic [11:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_esc;
  logic [7:0]  r_data;
  logic        r_strobe;
  logic        r_flag;
  logic        r_err;

  logic        r_sync1;
  logic        r_sync2;
  logic [1:0]  r_settle;
  logic        r_prev;

  logic        w_rxd;
  logic        w_settled;
  logic        w_fall;
  logic        w_expire;

  // Synchronizer output is only trusted once both flops hold
  // real pin samples; until then the edge detector stays disarmed
  // so a line held low across reset cannot look like a start bit.
  assign w_rxd     = r_sync2;
  assign w_settled = (r_settle == 2'd2);
  assign w_fall    = w_settled & r_prev & ~w_rxd;
  assign w_expire  = (r_timer == 12'd0);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_settle <= 2'd0;
      r_prev   <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      if (!w_settled)
        r_settle <= r_settle + 2'd1;
      r_prev <= w_settled ? w_rxd : 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timer  <= 12'd0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_esc    <= 1'b0;
      r_data   <= 8'h00;
      r_strobe <= 1'b0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_timer <= HALF;
          end
        end
        START: begin
          if (!w_expire) begin
            r_timer <= r_timer - 12'd1;
          end else if (!w_rxd) begin
            r_state <= DATA;
            r_timer <= FULL;
            r_idx   <= 3'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (!w_expire) begin
            r_timer <= r_timer - 12'd1;
          end else begin
            r_shift <= {w_rxd, r_shift[7:1]};
            r_timer <= FULL;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_idx   <= 3'd0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (!w_expire) begin
            r_timer <= r_timer - 12'd1;
          end else if (w_rxd) begin
            r_state <= IDLE;
            // A flag always wins and cancels any pending escape,
            // so a stray ESC cannot corrupt the next packet.
            if (r_shift == FLAG_BYTE) begin
              r_flag <= 1'b1;
              r_esc  <= 1'b0;
            end else if (r_esc) begin
              r_data   <= r_shift ^ ESC_XOR;
              r_strobe <= 1'b1;
              r_esc    <= 1'b0;
            end else if (r_shift == ESC_BYTE) begin
              r_esc <= 1'b1;
            end else begin
              r_data   <= r_shift;
              r_strobe <= 1'b1;
            end
          end else begin
            r_state <= BREAK_WAIT;
            r_err   <= 1'b1;
            r_esc   <= 1'b0;
          end
        end
        BREAK_WAIT: begin
          if (w_rxd)
            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_data        = r_data;
  assign rx_data_strobe = r_strobe;
  assign rx_flag        = r_flag;
  assign rx_frame_err   = r_err;

endmodule

// File: tb/tb_uart_rx_unescape.sv
// Directed bench for uart_rx_unescape at BIT_CLKS = 8.
// Pulses are logged into an event queue and compared to hand-built lists.
module tb_uart_rx_unescape;

  localparam int BC = 8;

  logic       mclk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_data_strobe;
  logic       rx_flag;
  logic       rx_frame_err;

  int total = 0;
  int bad   = 0;

  // event word: {kind, data}; kind 1 strobe, 2 flag, 3 err, FF multi
  logic [15:0] ev_q[$];
  logic [15:0] exp_q[$];

  uart_rx_unescape #(
    .BIT_CLKS (BC)
  ) dut (
    .mclk           (mclk),
    .reset          (reset),
    .rxd            (rxd),
    .rx_data        (rx_data),
    .rx_data_strobe (rx_data_strobe),
    .rx_flag        (rx_flag),
    .rx_frame_err   (rx_frame_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    int n;
    n = int'(rx_data_strobe) + int'(rx_flag) + int'(rx_frame_err);
    if (n > 1)
      ev_q.push_back(16'hFF00);
    else if (rx_data_strobe)
      ev_q.push_back({8'h01, rx_data});
    else if (rx_flag)
      ev_q.push_back(16'h0200);
    else if (rx_frame_err)
      ev_q.push_back(16'h0300);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    rxd = 1'b0;
    wait_clks(BC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BC);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      wait_clks(BC * stop_low);
    end
    rxd = 1'b1;
    wait_clks(BC * 3);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, " count"}, 16'(ev_q.size()), 16'(exp_q.size()));
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s ev%0d", tag, i), ev_q[i], exp_q[i]);
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rxd   = 1'b1;
    reset = 1'b0;
    wait_clks(3);
    #1;
    chk("reset rx_data", {8'h00, rx_data}, 16'h0000);
    chk("reset pulses",
        {13'd0, rx_data_strobe, rx_flag, rx_frame_err}, 16'h0000);
    reset = 1'b1;
    wait_clks(20);
    ev_q.delete();

    send_byte(8'hA5, 0);
    exp_q.push_back(16'h01A5);
    check_events("clean A5");

    send_byte(8'h7E, 0);
    send_byte(8'h01, 0);
    send_byte(8'h7D, 0);
    send_byte(8'h5E, 0);
    send_byte(8'h7D, 0);
    send_byte(8'h7D, 0);
    send_byte(8'h7E, 0);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h017E);
    exp_q.push_back(16'h015D);
    exp_q.push_back(16'h0200);
    check_events("escape seq");
    chk("hold after flag", {8'h00, rx_data}, 16'h005D);

    send_byte(8'h7D, 0);
    send_byte(8'h7E, 0);
    send_byte(8'h41, 0);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0141);
    check_events("esc cancel");

    send_byte(8'h55, 3);
    exp_q.push_back(16'h0300);
    check_events("frame err");
    chk("hold after err", {8'h00, rx_data}, 16'h0041);
    send_byte(8'h33, 0);
    exp_q.push_back(16'h0133);
    check_events("after err 33");

    rxd = 1'b0;
    wait_clks(BC);
    rxd = 1'b1;
    wait_clks(BC * 4 + 4);
    reset = 1'b0;
    #1;
    chk("midbyte rst data", {8'h00, rx_data}, 16'h0000);
    wait_clks(3);
    reset = 1'b1;
    wait_clks(2 * BC);
    chk("post rst data", {8'h00, rx_data}, 16'h0000);
    send_byte(8'hC3, 0);
    exp_q.push_back(16'h01C3);
    check_events("midbyte rst");

    rxd   = 1'b0;
    reset = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(BC * 12);
    check_events("low across rst");
    rxd = 1'b1;
    wait_clks(2 * BC);
    send_byte(8'h96, 0);
    exp_q.push_back(16'h0196);
    check_events("after low rst");

    rxd = 1'b0;
    wait_clks(2);
    rxd = 1'b1;
    wait_clks(BC * 4);
    check_events("glitch");
    send_byte(8'h00, 0);
    exp_q.push_back(16'h0100);
    check_events("after glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
